alu_multicycle: RTL

// Parametrised successor to the SAP-1.5 single-op ALU: WIDTH-bit datapath, 4-bit opcode, carry-in ops
// (ADC/SBC), XOR/NOT/INC/DEC, and iterative multi-bit shifts/rotates (one bit per clock).

---
 rtl/alu_multicycle.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops, iterative one-bit-per-clock shifts/rotates,
// with a start/busy/done handshake and registered result and Z/C/N/V flags.
module alu_multicycle #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_out,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             negative_flag,
    output logic             overflow_flag
);

    localparam int unsigned SHAMT_W = $clog2(WIDTH);
    localparam int unsigned MSB     = WIDTH - 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_ADC = 4'd5;
    localparam logic [3:0] OP_SBC = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_ROL = 4'd9;
    localparam logic [3:0] OP_ROR = 4'd10;
    localparam logic [3:0] OP_INC = 4'd11;
    localparam logic [3:0] OP_DEC = 4'd12;
    localparam logic [3:0] OP_NOT = 4'd13;

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] count;
    logic [3:0]         sh_op;

    logic [SHAMT_W-1:0] amount;
    logic               is_shift;
    logic [WIDTH:0]     wide;
    logic [WIDTH-1:0]   one;
    logic [WIDTH:0]     cin_ext;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;
    logic [WIDTH-1:0]   step_work;
    logic               step_out;

    assign amount   = b_in[SHAMT_W-1:0];
    assign is_shift = (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) || (op == OP_ROR);
    assign one      = WIDTH'(1);
    assign cin_ext  = {{WIDTH{1'b0}}, carry_flag};

    // Single-cycle result and flags for the op presented at the inputs
    always_comb begin
        wide    = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD, OP_ADC, OP_INC: begin
                if (op == OP_INC) begin
                    wide  = {1'b0, a_in} + {1'b0, one};
                    alu_v = (a_in[MSB] == one[MSB]) && (wide[MSB] != a_in[MSB]);
                end else begin
                    wide = {1'b0, a_in} + {1'b0, b_in} + ((op == OP_ADC) ? cin_ext : '0);
                    alu_v = (a_in[MSB] == b_in[MSB]) && (wide[MSB] != a_in[MSB]);
                end
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
            end
            OP_SUB, OP_SBC, OP_DEC: begin
                if (op == OP_DEC) begin
                    wide  = {1'b0, a_in} - {1'b0, one};
                    alu_v = (a_in[MSB] != one[MSB]) && (wide[MSB] != a_in[MSB]);
                end else begin
                    wide = {1'b0, a_in} - {1'b0, b_in} - ((op == OP_SBC) ? cin_ext : '0);
                    alu_v = (a_in[MSB] != b_in[MSB]) && (wide[MSB] != a_in[MSB]);
                end
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
            end
            OP_AND: alu_res = a_in & b_in;
            OP_OR:  alu_res = a_in | b_in;
            OP_XOR: alu_res = a_in ^ b_in;
            OP_NOT: alu_res = ~a_in;
            // Zero shift amount completes immediately with the operand unchanged
            OP_SHL, OP_SHR, OP_ROL, OP_ROR: alu_res = a_in;
            default: alu_res = '0;
        endcase
    end

    // One-bit step of the shift/rotate in progress
    always_comb begin
        step_work = work;
        step_out  = 1'b0;
        case (sh_op)
            OP_SHL: begin
                step_work = {work[WIDTH-2:0], 1'b0};
                step_out  = work[MSB];
            end
            OP_SHR: begin
                step_work = {1'b0, work[WIDTH-1:1]};
                step_out  = work[0];
            end
            OP_ROL: begin
                step_work = {work[WIDTH-2:0], work[MSB]};
                step_out  = work[MSB];
            end
            OP_ROR: begin
                step_work = {work[0], work[WIDTH-1:1]};
                step_out  = work[0];
            end
            default: begin
                step_work = work;
                step_out  = 1'b0;
            end
        endcase
    end

    // Control FSM with registered handshake, result and flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            work          <= '0;
            count         <= '0;
            sh_op         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            result_out    <= '0;
            zero_flag     <= 1'b0;
            carry_flag    <= 1'b0;
            negative_flag <= 1'b0;
            overflow_flag <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (is_shift && (amount != '0)) begin
                            work  <= a_in;
                            count <= amount;
                            sh_op <= op;
                            busy  <= 1'b1;
                            state <= S_SHIFT;
                        end else begin
                            result_out    <= alu_res;
                            zero_flag     <= (alu_res == '0);
                            carry_flag    <= alu_c;
                            negative_flag <= alu_res[MSB];
                            overflow_flag <= alu_v;
                            done          <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    work  <= step_work;
                    count <= count - SHAMT_W'(1);
                    // The last bit step writes the result directly so latency is amount+1
                    if (count == SHAMT_W'(1)) begin
                        result_out    <= step_work;
                        zero_flag     <= (step_work == '0);
                        carry_flag    <= step_out;
                        negative_flag <= step_work[MSB];
                        overflow_flag <= 1'b0;
                        done          <= 1'b1;
                        busy          <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
